// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus bridge: register map, TX sequencer states
// and the power-on baud divisor.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_STAT  = 2'd1;
    localparam logic [1:0] ADDR_BAUDL = 2'd2;
    localparam logic [1:0] ADDR_BAUDH = 2'd3;

    // 50 MHz / 115200
    localparam logic [11:0] BAUD_RST_DEFAULT = 12'd434;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } tx_state_t;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// CPU-side register bus of the UART bridge: chip select, direction, 2-bit
// address, write data and registered read data.
interface uart_bus_bridge_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output iocs, output iorw, output ioaddr, output wdata, input rdata);
    modport slave  (input iocs, input iorw, input ioaddr, input wdata, output rdata);

endinterface

// File: rtl/uart_bus_bridge_fifo.sv
// Synchronous FIFO with a combinational head; push/pop must already be
// qualified by the caller against full/empty.
module uart_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_bus_bridge.sv
// Memory-mapped bridge between a CPU register bus and a UART: buffers TX and RX
// bytes in FIFOs, sequences trmt/tx_done handshakes and holds the baud divisor.
module uart_bus_bridge
    import uart_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [11:0] BAUD_RST = BAUD_RST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_bus_bridge_if.slave    bus,
    output logic [7:0]          tx_data,
    output logic                trmt,
    input  logic                tx_done,
    input  logic [7:0]          rx_data,
    input  logic                rx_rdy,
    output logic                clr_rx_rdy,
    output logic [11:0]         baud_goal
);

    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_t       state;
    logic            overrun;
    logic            wr, rd;
    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic            rx_push, rx_pop, rx_full, rx_empty, rx_take;
    logic [7:0]      tx_head, rx_head;
    logic [CW-1:0]   tx_count, rx_count;
    logic [3:0]      tx_free;

    assign wr = bus.iocs & ~bus.iorw;
    assign rd = bus.iocs &  bus.iorw;

    // A full FIFO still accepts when the same cycle frees a slot.
    assign tx_pop  = (state == IDLE) & ~tx_empty;
    assign tx_push = wr & (bus.ioaddr == ADDR_DATA) & (~tx_full | tx_pop);

    // clr_rx_rdy high means the UART has not yet dropped rx_rdy for the byte just taken.
    assign rx_take = rx_rdy & ~clr_rx_rdy;
    assign rx_pop  = rd & (bus.ioaddr == ADDR_DATA) & ~rx_empty;
    assign rx_push = rx_take & (~rx_full | rx_pop);

    assign tx_free = 4'(DEPTH) - 4'(tx_count);

    uart_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus.wdata),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            trmt    <= 1'b0;
            tx_data <= '0;
        end else begin
            trmt <= 1'b0;
            case (state)
                IDLE: if (!tx_empty) begin
                    tx_data <= tx_head;
                    trmt    <= 1'b1;
                    state   <= LAUNCH;
                end
                // Let a tx_done left over from the previous frame fall first.
                LAUNCH:  if (!tx_done) state <= WAIT;
                WAIT:    if (tx_done)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_rx_rdy <= 1'b0;
            overrun    <= 1'b0;
            baud_goal  <= BAUD_RST;
        end else begin
            clr_rx_rdy <= rx_take;
            if (rx_take && rx_full && !rx_pop)
                overrun <= 1'b1;
            else if (wr && bus.ioaddr == ADDR_BAUDH)
                overrun <= 1'b0;
            if (wr && bus.ioaddr == ADDR_BAUDL) baud_goal[7:0]  <= bus.wdata;
            if (wr && bus.ioaddr == ADDR_BAUDH) baud_goal[11:8] <= bus.wdata[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= '0;
        end else if (rd) begin
            case (bus.ioaddr)
                ADDR_DATA:  bus.rdata <= rx_empty ? 8'h00 : rx_head;
                ADDR_STAT:  bus.rdata <= {tx_free, 4'(rx_count)};
                ADDR_BAUDL: bus.rdata <= baud_goal[7:0];
                default:    bus.rdata <= {overrun, 3'b000, baud_goal[11:8]};
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized bench for uart_bus_bridge: a UART model plus queue-based reference
// of both FIFOs, the overrun flag and the baud register.
module tb_uart_bus_bridge;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [11:0] baud_goal;

    uart_bus_bridge_if bus ();

    uart_bus_bridge #(.DEPTH(DEPTH), .BAUD_RST(12'd434)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .baud_goal  (baud_goal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    logic [7:0]  exp_tx[$];
    logic [7:0]  sent_q[$];
    logic [7:0]  rx_q[$];
    logic        exp_ov   = 1'b0;
    logic [11:0] exp_baud = 12'd434;
    int          exp_clr  = 0;

    // UART model controls and observations
    bit tx_stall = 1'b0;
    bit rand_lat = 1'b0;
    int fixed_lat = 20;
    bit busy = 1'b0;
    int timer = 0;
    int trmt_cnt = 0;
    int clr_cnt = 0;
    logic trmt_prev = 1'b0;
    logic clr_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && trmt) begin
                chk("trmt_width", 32'(trmt_prev), 0);
                chk("tx_overlap", 32'(busy), 0);
                sent_q.push_back(tx_data);
                trmt_cnt++;
                busy    = 1'b1;
                tx_done = 1'b0;
                timer   = rand_lat ? int'($urandom_range(2, 25)) : fixed_lat;
            end else if (busy && !tx_stall) begin
                timer--;
                if (timer <= 0) begin
                    tx_done = 1'b1;
                    busy    = 1'b0;
                end
            end
            if (rst_n && clr_rx_rdy) begin
                chk("clr_width", 32'(clr_prev), 0);
                clr_cnt++;
            end
            trmt_prev = trmt;
            clr_prev  = clr_rx_rdy;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; bus.wdata = d;
        @(negedge clk);
        bus.iocs = 1'b0;
        if (a == 2'd2) exp_baud[7:0] = d;
        if (a == 2'd3) begin exp_baud[11:8] = d[3:0]; exp_ov = 1'b0; end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        @(negedge clk);
        bus.iocs = 1'b0;
        d = bus.rdata;
    endtask

    function automatic logic [7:0] exp_status();
        int pending = exp_tx.size() - sent_q.size();
        return {4'(DEPTH - pending), 4'(rx_q.size())};
    endfunction

    task automatic tx_write(input logic [7:0] b);
        if ((exp_tx.size() - sent_q.size()) < DEPTH) exp_tx.push_back(b);
        bus_write(2'd0, b);
    endtask

    task automatic tx_drain_check(input string tag);
        for (int i = 0; i < 4000 && sent_q.size() < exp_tx.size(); i++) @(negedge clk);
        repeat (40) @(negedge clk);
        chk({tag, "_frames"}, sent_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < sent_q.size(); i++)
            chk({tag, "_byte"}, sent_q[i], exp_tx[i]);
        exp_tx.delete();
        sent_q.delete();
    endtask

    task automatic rx_inject(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) break;
        end
        rx_rdy = 1'b0;
        exp_clr++;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else exp_ov = 1'b1;
    endtask

    task automatic rx_read_check(input string tag);
        logic [7:0] d, e;
        e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        bus_read(2'd0, d);
        chk(tag, d, e);
    endtask

    logic [7:0] rd;
    logic [11:0] nb;
    int n, snap;

    initial begin
        rst_n = 1'b0;
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = '0; bus.wdata = '0;
        rx_data = '0; rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_trmt", 32'(trmt), 0);
        chk("rst_clr", 32'(clr_rx_rdy), 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_baud", baud_goal, 12'd434);
        bus_read(2'd2, rd); chk("rst_baudl", rd, 8'hB2);
        bus_read(2'd3, rd); chk("rst_baudh", rd, 8'h01);
        bus_read(2'd1, rd); chk("rst_status", rd, 8'h80);
        bus_read(2'd0, rd); chk("rst_rx_empty", rd, 8'h00);

        // Baud register round trip
        for (int k = 0; k < 3; k++) begin
            nb = 12'($urandom);
            bus_write(2'd2, nb[7:0]);
            bus_write(2'd3, {4'($urandom), nb[11:8]});
            chk("baud_goal", baud_goal, exp_baud);
            bus_read(2'd2, rd); chk("baudl_rd", rd, exp_baud[7:0]);
            bus_read(2'd3, rd); chk("baudh_rd", rd, {exp_ov, 3'b000, exp_baud[11:8]});
        end

        // Two frames with a fixed 20-cycle UART
        snap = trmt_cnt;
        tx_write(8'h55);
        tx_write(8'hA3);
        tx_drain_check("tx_pair");
        chk("tx_pair_pulses", trmt_cnt - snap, 2);

        // Random bursts with random frame lengths
        rand_lat = 1'b1;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) tx_write(8'($urandom));
            tx_drain_check("tx_rand");
        end
        rand_lat = 1'b0;

        // Stalled UART: one byte in flight plus a full FIFO, then one dropped
        tx_stall = 1'b1;
        tx_write(8'($urandom));
        for (int i = 0; i < 50 && sent_q.size() == 0; i++) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) tx_write(8'($urandom));
        bus_read(2'd1, rd); chk("stall_status", rd, exp_status());
        chk("stall_free0", rd[7:4], 0);
        tx_write(8'($urandom));
        bus_read(2'd1, rd); chk("stall_drop_status", rd, exp_status());
        chk("stall_accepted", exp_tx.size(), 9);
        tx_stall = 1'b0;
        tx_drain_check("tx_stall");

        // Directed receive
        rx_inject(8'h3C);
        rx_inject(8'h7E);
        repeat (2) @(negedge clk);
        chk("rx_clr_pulses", clr_cnt, exp_clr);
        bus_read(2'd1, rd); chk("rx_status", rd, exp_status());
        rx_read_check("rx_byte0");
        rx_read_check("rx_byte1");
        rx_read_check("rx_empty_read");

        // Read of an empty FIFO coinciding with a push
        @(negedge clk);
        rx_data = 8'hC7; rx_rdy = 1'b1;
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'd0;
        @(negedge clk);
        bus.iocs = 1'b0; rx_rdy = 1'b0;
        chk("rx_coincident_read", bus.rdata, 8'h00);
        rx_q.push_back(8'hC7); exp_clr++;
        rx_read_check("rx_coincident_kept");

        // Random overflow
        n = $urandom_range(DEPTH + 1, DEPTH + 4);
        for (int i = 0; i < n; i++) rx_inject(8'($urandom));
        repeat (2) @(negedge clk);
        chk("ovf_clr_pulses", clr_cnt, exp_clr);
        bus_read(2'd1, rd); chk("ovf_status", rd, exp_status());
        bus_read(2'd3, rd); chk("ovf_flag", rd, {exp_ov, 3'b000, exp_baud[11:8]});
        chk("ovf_flag_set", rd[7], 1);
        bus_write(2'd3, {4'h0, exp_baud[11:8]});
        bus_read(2'd3, rd); chk("ovf_clear", rd, {exp_ov, 3'b000, exp_baud[11:8]});
        for (int i = 0; i < DEPTH; i++) rx_read_check("ovf_byte");
        rx_read_check("ovf_drained");

        // Asynchronous reset during a frame with bytes queued
        fixed_lat = 60;
        for (int i = 0; i < 4; i++) tx_write(8'($urandom));
        for (int i = 0; i < 50 && sent_q.size() == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_trmt", 32'(trmt), 0);
        chk("arst_txdata", tx_data, 0);
        chk("arst_rdata", bus.rdata, 0);
        chk("arst_clr", 32'(clr_rx_rdy), 0);
        chk("arst_baud", baud_goal, 12'd434);
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_tx.delete(); sent_q.delete(); rx_q.delete();
        exp_ov = 1'b0; exp_baud = 12'd434;
        snap = trmt_cnt;
        repeat (120) @(negedge clk);
        chk("arst_no_trmt", trmt_cnt - snap, 0);
        bus_read(2'd1, rd); chk("arst_status", rd, 8'h80);
        bus_read(2'd3, rd); chk("arst_baudh", rd, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
